// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined add/sub/accumulate unit with valid/ready on both sides
module adder_pipe #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 16,
    parameter int STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    generate
        if (WIDTH < 2 || OUT_WIDTH < WIDTH + 1 || STAGES < 1 || STAGES > 4) begin : g_bad_params
            $error("adder_pipe: illegal WIDTH/OUT_WIDTH/STAGES combination");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] a_ext;
    logic [OUT_WIDTH-1:0] b_ext;
    logic [OUT_WIDTH:0]   acc_sum;
    logic [OUT_WIDTH-1:0] res;
    logic                 res_ovf;
    logic                 stall;
    logic                 accept;

    logic [STAGES-1:0]    vld;
    logic [STAGES-1:0]    flg;
    logic [OUT_WIDTH-1:0] data [STAGES];

    assign stall    = vld[STAGES-1] && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    assign a_ext   = OUT_WIDTH'(a);
    assign b_ext   = OUT_WIDTH'(b);
    assign acc_sum = {1'b0, acc} + {1'b0, a_ext} + {1'b0, b_ext};

    // Result and flag are fully resolved at accept time and only carried down the pipe.
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        case (op_t'(op))
            OP_ADD: res = a_ext + b_ext;
            OP_SUB: begin
                res     = a_ext - b_ext;
                res_ovf = (a < b);
            end
            OP_ACC: begin
                res     = acc_sum[OUT_WIDTH-1:0];
                res_ovf = acc_sum[OUT_WIDTH];
            end
            OP_CLR: res = acc;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            flg <= '0;
            acc <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (accept && op_t'(op) == OP_ACC) begin
                acc <= acc_sum[OUT_WIDTH-1:0];
            end else if (accept && op_t'(op) == OP_CLR) begin
                acc <= '0;
            end
            // A stall freezes the whole pipe; data regs load only behind a valid token.
            if (!stall) begin
                vld[0] <= accept;
                if (accept) begin
                    data[0] <= res;
                    flg[0]  <= res_ovf;
                end
                for (int i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        data[i] <= data[i-1];
                        flg[i]  <= flg[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out       = data[STAGES-1];
    assign ovf       = flg[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe at STAGES 2, 1 and 4
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [1:0]  op = '0;

    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  ovf_v;
    logic [15:0] out_v [3];

    logic [16:0] got_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int st_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int ST = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
        logic [16:0] exp_q [$];
        logic [16:0] prev = '0;
        logic        was_stall = 1'b0;
        int          macc = 0;

        adder_pipe #(.WIDTH(8), .OUT_WIDTH(16), .STAGES(ST)) dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[k]),
            .a         (a),
            .b         (b),
            .op        (op),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready),
            .out       (out_v[k]),
            .ovf       (ovf_v[k])
        );

        // Inputs settle right after posedge; everything is sampled at the following negedge.
        always @(negedge clk) begin
            logic [16:0] e;
            int          s;
            if (reset) begin
                exp_q.delete();
                macc      = 0;
                was_stall = 1'b0;
            end else begin
                if (was_stall)
                    check("stall_hold", {out_valid_v[k], ovf_v[k], out_v[k]}, {1'b1, prev});
                check("in_ready", in_ready_v[k], !(out_valid_v[k] && !out_ready));
                if (out_valid_v[k] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {ovf_v[k], out_v[k]}, e);
                        if (k == 0) got_q.push_back({ovf_v[k], out_v[k]});
                    end
                end
                if (in_valid && in_ready_v[k]) begin
                    case (op)
                        2'd0: e = 17'(int'(a) + int'(b));
                        2'd1: begin
                            s = int'(a) - int'(b);
                            e = {(a < b), 16'(s)};
                        end
                        2'd2: begin
                            s = macc + int'(a) + int'(b);
                            e = {(s > 65535), 16'(s)};
                            macc = s % 65536;
                        end
                        default: begin
                            e = {1'b0, 16'(macc)};
                            macc = 0;
                        end
                    endcase
                    exp_q.push_back(e);
                end
                was_stall = out_valid_v[k] && !out_ready;
                prev      = {ovf_v[k], out_v[k]};
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        bit ok;
        int tries;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        ok = 1'b0;
        tries = 0;
        while (!ok && tries < 50) begin
            @(negedge clk);
            ok = in_ready_v[0];
            @(posedge clk);
            #1;
            tries++;
        end
        if (!ok) check("send_timeout", tries, 0);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int sz;

        // Power-on reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("por_valid", out_valid_v[k], 0);
            check("por_out", out_v[k], 0);
            check("por_ovf", ovf_v[k], 0);
            check("por_ready", in_ready_v[k], 1);
        end
        @(posedge clk);
        #1;

        // Reset with two requests in flight
        send(2'd2, 8'd10, 8'd20);
        send(2'd0, 8'd1, 8'd2);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", out_valid_v[k], 0);
            check("rst_out", out_v[k], 0);
            check("rst_ovf", ovf_v[k], 0);
            check("rst_ready", in_ready_v[k], 1);
        end
        @(posedge clk);
        #1;
        base = got_q.size();
        send(2'd3, 8'd0, 8'd0);
        drain();
        check("rst_nres", got_q.size() - base, 1);
        check("rst_acc", got_q[base], 17'd0);

        // Latency and ADD
        base = got_q.size();
        send(2'd0, 8'd7, 8'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_early", out_valid_v[0], 0);
        @(negedge clk);
        check("lat_valid", out_valid_v[0], 1);
        check("lat_out", out_v[0], 16'd8);
        @(posedge clk);
        #1;
        send(2'd0, 8'd255, 8'd255);
        drain();
        check("add_510", got_q[base+1], 17'd510);

        // SUB
        base = got_q.size();
        send(2'd1, 8'd6, 8'd8);
        send(2'd1, 8'd8, 8'd6);
        drain();
        check("sub_neg", got_q[base], 17'h1FFFE);
        check("sub_pos", got_q[base+1], 17'h00002);

        // ACC / CLR back to back
        base = got_q.size();
        send(2'd2, 8'd71, 8'd23);
        send(2'd2, 8'd14, 8'd11);
        send(2'd3, 8'd0, 8'd0);
        send(2'd2, 8'd5, 8'd6);
        drain();
        check("acc_94", got_q[base], 17'd94);
        check("acc_119", got_q[base+1], 17'd119);
        check("clr_119", got_q[base+2], 17'd119);
        check("acc_11", got_q[base+3], 17'd11);

        // Accumulator wrap from 16'hFFFF
        send(2'd3, 8'd0, 8'd0);
        for (int i = 0; i < 128; i++) send(2'd2, 8'd255, 8'd255);
        send(2'd2, 8'd255, 8'd0);
        send(2'd2, 8'd1, 8'd0);
        drain();
        sz = got_q.size();
        check("acc_ffff", got_q[sz-2], 17'h0FFFF);
        check("acc_wrap", got_q[sz-1], 17'h10000);

        // Backpressure: six ADDs, consumer stalls for 5 cycles
        base = got_q.size();
        fork
            begin
                for (int i = 0; i < 6; i++) send(2'd0, 8'(i * 10 + 1), 8'(i + 3));
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (w < 50) begin
                    @(negedge clk);
                    if (out_valid_v[0]) break;
                    w++;
                end
                if (w >= 50) check("bp_timeout", w, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", got_q.size() - base, 6);
        for (int i = 0; i < 6; i++) check("bp_res", got_q[base+i], 17'(11 * i + 4));

        // Full rate with random ops
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (i >= st_of(k)) check("full_rate", out_valid_v[k], 1);
            end
            @(posedge clk);
            #1;
        end
        drain();

        check("drain_s2", g_dut[0].exp_q.size(), 0);
        check("drain_s1", g_dut[1].exp_q.size(), 0);
        check("drain_s4", g_dut[2].exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
